// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, writeback
// control bit positions and the wait-state counter width.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bit positions inside the 2-bit writeback control bundle.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Wait-state counter width; covers LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_memory #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // Store the word on the edge that completes a write access.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access.sv
// Memory stage of the five-stage pipeline. Resolves the branch, performs
// loads/stores with a configurable latency (wait-state FSM stalls upstream)
// and registers the MEM/WB latch.
//
// Handshake: a request (memread | memwrite) is accepted when presented;
// while stall is high the EX/MEM inputs must be held constant, and the
// access completes on the first edge at which stall is low.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  write_reg
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               request;
  logic               mem_we;
  logic [ADDR_W-1:0]  word_addr;
  logic [31:0]        mem_rdata;

  logic [1:0]         wb_ctl_q;
  logic [31:0]        read_data_q;
  logic [31:0]        mem_alu_result_q;
  logic [4:0]         write_reg_q;

  // Byte-offset bits and out-of-range upper bits are ignored (address wraps).
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{alu_result[31:ADDR_W+2], alu_result[1:0]};

  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;
  assign request       = memread | memwrite;
  assign word_addr     = alu_result[ADDR_W+1:2];

  // A store is committed only on its completing edge, and never while in reset.
  assign mem_we = memwrite & ~stall & rst_n;

  data_memory #(
    .ADDR_W (ADDR_W)
  ) u_data_memory (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (word_addr),
    .wdata_i (rdata2out),
    .rdata_o (mem_rdata)
  );

  // Wait-state FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (request && (LATENCY > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          stall   = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!rst_n) begin
      stall = 1'b0;
    end
  end

  // MEM/WB latch: bubble on stall edges, otherwise capture the stage result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctl_q         <= 2'b00;
      read_data_q      <= '0;
      mem_alu_result_q <= '0;
      write_reg_q      <= '0;
    end else if (stall) begin
      wb_ctl_q <= 2'b00;
    end else begin
      wb_ctl_q[WB_REGWRITE] <= wb_ctl[WB_REGWRITE];
      wb_ctl_q[WB_MEMTOREG] <= wb_ctl[WB_MEMTOREG];
      mem_alu_result_q      <= alu_result;
      write_reg_q           <= five_bit_muxout;
      read_data_q           <= (memread && !memwrite) ? mem_rdata : 32'h0;
    end
  end

  assign wb_ctl_out     = wb_ctl_q;
  assign read_data      = read_data_q;
  assign mem_alu_result = mem_alu_result_q;
  assign write_reg      = write_reg_q;

endmodule
